// File: rtl/adc_frame_ctrl.sv
`default_nettype none
// ============================================================================
// Module  : adc_frame_ctrl
// Brief   : ADC sample-clock generator and single-frame capture sequencer.
// Revision: 1.0 - initial release
// ============================================================================
module adc_frame_ctrl #(
  parameter int          PHASE_W   = 32,
  parameter int unsigned PHASE_INC = 439804651,
  parameter int          FRAME_LEN = 1024,
  parameter int          ADDR_W    = 10,
  parameter int          SETTLE    = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic              frame_ack,
  input  logic [7:0]        AD0,
  output logic              AD0_CLK,
  output logic              wr_en,
  output logic [ADDR_W-1:0] wr_addr,
  output logic [7:0]        wr_data,
  output logic              busy,
  output logic              frame_ready,
  output logic              overrun
);

  localparam logic [PHASE_W-1:0] INC       = PHASE_W'(PHASE_INC);
  localparam int                 CNT_W     = (SETTLE > 0) ? $clog2(SETTLE + 1) : 1;
  localparam logic [CNT_W-1:0]   SETTLE_LAST = CNT_W'(SETTLE - 1);
  localparam logic [ADDR_W-1:0]  ADDR_LAST = ADDR_W'(FRAME_LEN - 1);

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_SETTLE  = 2'd1,
    ST_CAPTURE = 2'd2,
    ST_DONE    = 2'd3
  } state_t;

  state_t             state;
  state_t             state_nxt;
  logic [PHASE_W-1:0] acc;
  logic [CNT_W-1:0]   settle_cnt;
  logic               strobe;
  logic               last_settle;
  logic               last_addr;

  // Strobe marks the edge on which AD0_CLK falls: the data is mid-eye there.
  assign strobe      = AD0_CLK & ~acc[PHASE_W-1];
  assign last_settle = (settle_cnt == SETTLE_LAST);
  assign last_addr   = (wr_addr == ADDR_LAST);
  assign busy        = (state == ST_SETTLE) || (state == ST_CAPTURE);
  assign frame_ready = (state == ST_DONE);

  always_ff @(posedge clk) begin
    if (reset) begin
      acc     <= '0;
      AD0_CLK <= 1'b0;
    end else begin
      acc     <= acc + INC;
      AD0_CLK <= acc[PHASE_W-1];
    end
  end

  always_ff @(posedge clk) begin
    if (reset) state <= ST_IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE:    if (start) state_nxt = (SETTLE == 0) ? ST_CAPTURE : ST_SETTLE;
      ST_SETTLE:  if (strobe && last_settle) state_nxt = ST_CAPTURE;
      ST_CAPTURE: if (wr_en && last_addr) state_nxt = ST_DONE;
      ST_DONE:    if (frame_ack) state_nxt = ST_IDLE;
      default:    state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_en      <= 1'b0;
      wr_addr    <= '0;
      wr_data    <= '0;
      settle_cnt <= '0;
      overrun    <= 1'b0;
    end else begin
      wr_en <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (start) begin
            wr_addr    <= '0;
            settle_cnt <= '0;
            overrun    <= 1'b0;
          end
        end
        ST_SETTLE: begin
          if (strobe) settle_cnt <= settle_cnt + CNT_W'(1);
        end
        ST_CAPTURE: begin
          // Address advances the cycle after each write so wr_addr is valid with wr_en.
          if (strobe) begin
            wr_en   <= 1'b1;
            wr_data <= AD0 ^ 8'h80;
          end else if (wr_en && !last_addr) begin
            wr_addr <= wr_addr + ADDR_W'(1);
          end
        end
        default: ;
      endcase
      if (start && (state != ST_IDLE)) overrun <= 1'b1;
    end
  end

endmodule
`default_nettype wire

// File: doc/adc_frame_ctrl.md
# adc_frame_ctrl

Sequencer for the 8-bit ADC front end (AD0 / AD0_CLK). Generates the ADC sample clock from the 50 MHz system clock with a fractional phase accumulator (default 5.12 MHz). On a start request it discards a settle window, then writes one fixed-length frame of offset-binary-to-signed converted samples into the downstream frame buffer. It then holds the frame for the FFT/separation stage until acknowledged.

## Interface
- PHASE_W, 32: phase accumulator width
- PHASE_INC, 439804651: per-clk phase step; f_AD0_CLK = 50 MHz × PHASE_INC / 2^PHASE_W (5.12 MHz)
- FRAME_LEN, 1024: samples written per frame (≥1)
- ADDR_W, 10: buffer address width; 2^ADDR_W ≥ FRAME_LEN
- SETTLE, 4: samples discarded after start (0 allowed)

- clk  in  1  system clock, 50 MHz; one clock; all logic on rising edge
- reset  in  1  synchronous, active-high
- start  in  1  frame request, sampled every cycle
- frame_ack  in  1  consumer has read the frame
- AD0  in  8  ADC data, offset binary
- AD0_CLK  out  1  ADC sample clock, registered
- wr_en  out  1  buffer write strobe, one cycle per sample
- wr_addr  out  ADDR_W  buffer write address
- wr_data  out  8  signed sample (two's complement)
- busy  out  1  high in SETTLE/CAPTURE
- frame_ready  out  1  high in DONE
- overrun  out  1  sticky: start rejected while not IDLE

## Operation
- Phase accumulator `acc` runs every cycle from reset, independent of state: acc <= acc + PHASE_INC, modulo 2^PHASE_W. AD0_CLK = registered acc MSB.
- Sample strobe: the cycle edge at which AD0_CLK goes 1→0 (mid-period, ADC data stable). AD0 is captured at that edge.
- Conversion: wr_data = AD0 ^ 8'h80 (0x00→-128, 0x80→0, 0xFF→+127).
- States:
  - IDLE: start=1 → SETTLE, or → CAPTURE when SETTLE=0. wr_addr<=0, settle count<=0, overrun<=0.
  - SETTLE: count strobes, no writes. After the SETTLE-th strobe → CAPTURE.
  - CAPTURE: each strobe gives wr_en=1 with current address and converted sample. Address increments after each write. After the write at address FRAME_LEN-1 → DONE.
  - DONE: frame_ready=1. frame_ack=1 → IDLE.
- start in any state other than IDLE is ignored and sets overrun=1. overrun clears only on reset or an accepted start.
- frame_ack outside DONE is ignored.
- A strobe in the same cycle start is accepted is not counted or written. Counting begins with the first strobe after entry into SETTLE/CAPTURE.
- wr_addr holds its last value outside CAPTURE and never exceeds FRAME_LEN-1.

## Timing
- Reset values: acc=0, AD0_CLK=0, wr_en=0, wr_addr=0, wr_data=0, busy=0, frame_ready=0, overrun=0, state IDLE.
- Reset asserted mid-operation: all of the above are in effect on the cycle after the reset edge. Any partial frame is abandoned.
- With the default PHASE_INC, the AD0_CLK period is 9 or 10 clk cycles, with an average of 9.765625. Each phase (high or low) is 4–5 cycles.
- Start latency: start high at edge N → busy high from cycle N+1.
- Write latency:
  - wr_en and wr_data update on the same edge as the AD0_CLK falling transition.
  - wr_en is high exactly one cycle.
  - wr_data holds until the next write.
- frame_ready rises on the cycle after the final wr_en cycle. busy falls on the same cycle.
- frame_ack high at edge M while in DONE → frame_ready=0 and IDLE from cycle M+1. start is accepted at M+1 at the earliest.
- Frame duration (start to frame_ready) ≈ (SETTLE + FRAME_LEN) AD0_CLK periods, within +1 period.

## Test plan
- Clock gen: release reset, run 50 000 clk → exactly 5120 ±1 AD0_CLK rising edges; every period is 9 or 10 clk cycles.
- Frame capture (FRAME_LEN=16, SETTLE=4, ADDR_W=4):
  - Stimulus: AD0 ramps +1 on each AD0_CLK rise, starting at 0x00; pulse start.
  - Required: exactly 16 wr_en pulses, wr_addr 0..15 in order, wr_data = ramp value ^ 0x80. The first written sample is the 5th strobe after start. frame_ready rises one cycle after the last write.
- Handshake:
  - frame_ack pulsed during CAPTURE → ignored, frame still completes.
  - frame_ready holds ≥100 cycles without ack.
  - ack → frame_ready=0 and busy=0 next cycle.
  - A new start then produces a second frame from wr_addr 0.
- Overrun: start pulsed mid-CAPTURE and during DONE → overrun=1, frame unaffected (16 writes). The next accepted start clears overrun.
- Reset mid-CAPTURE after 7 writes → next cycle all outputs are at their reset values. A fresh start yields a full 16-sample frame from address 0.
- Conversion and SETTLE=0: hold AD0 at 0x00, then 0x80, then 0xFF → wr_data 0x80, 0x00, 0x7F. With SETTLE=0, the first strobe after start is written at address 0.
